// File: rtl/mont_mul_radix.sv
// Radix-2^PBITS Montgomery modular multiplier: y = a*b*2^(-PBITS*ITER) mod m.
// The b and m digit-multiple tables are built in a short precompute phase, so
// the caller only provides raw operands, m_prime and the modulus bit length.
module mont_mul_radix #(
  parameter int NBITS = 2048,
  parameter int PBITS = 2,
  parameter int CNTW  = $clog2(NBITS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] m,
  input  logic [PBITS-1:0] m_prime,
  input  logic [CNTW-1:0]  m_size,
  output logic             busy,
  output logic [NBITS-1:0] y,
  output logic             err,
  output logic             done_p
);

  localparam int MLSIZE = 1 << PBITS;
  localparam int TW     = NBITS + PBITS;
  localparam int UW     = NBITS + PBITS + 1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_LOOP, S_FINAL, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [NBITS-1:0]  a_q, a_d;
  logic [NBITS-1:0]  b_q, b_d;
  logic [NBITS-1:0]  m_q, m_d;
  logic [PBITS-1:0]  mp_q, mp_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [PBITS-1:0]  j_q, j_d;
  logic [TW-1:0]     tb_q [MLSIZE];
  logic [TW-1:0]     tb_d [MLSIZE];
  logic [TW-1:0]     tm_q [MLSIZE];
  logic [TW-1:0]     tm_d [MLSIZE];
  logic [UW-1:0]     u_q, u_d;
  logic [NBITS-1:0]  y_q, y_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic [PBITS-1:0]  dig;
  logic [PBITS-1:0]  q;
  logic [UW-1:0]     s;
  logic [UW-1:0]     sum;
  logic [CNTW-1:0]   iter_calc;

  // Iteration count: ceil(m_size/PBITS), with a zero size still running once
  assign iter_calc = (m_size == '0) ? CNTW'(1)
                   : CNTW'((32'(m_size) + 32'(PBITS - 1)) / 32'(PBITS));

  // Next-state and datapath: capture, table build, digit loop, final reduce
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    mp_d    = mp_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    tb_d    = tb_q;
    tm_d    = tm_q;
    u_d     = u_q;
    y_d     = y_q;
    err_d   = err_q;
    done_d  = 1'b0;
    dig     = '0;
    q       = '0;
    s       = '0;
    sum     = '0;
    case (state_q)
      S_IDLE: begin
        if (start_p) begin
          a_d     = a;
          b_d     = b;
          m_d     = m;
          mp_d    = m_prime;
          cnt_d   = iter_calc;
          j_d     = PBITS'(1);
          u_d     = '0;
          err_d   = 1'b0;
          state_d = m[0] ? S_PRE : S_ERR;
        end
      end
      S_PRE: begin
        tb_d[j_q] = tb_q[j_q - 1'b1] + TW'(b_q);
        tm_d[j_q] = tm_q[j_q - 1'b1] + TW'(m_q);
        j_d       = j_q + 1'b1;
        if (j_q == PBITS'(MLSIZE - 1)) state_d = S_LOOP;
      end
      S_LOOP: begin
        dig   = a_q[PBITS-1:0];
        s     = u_q + UW'(tb_q[dig]);
        q     = s[PBITS-1:0] * mp_q;
        sum   = s + UW'(tm_q[q]);
        u_d   = sum >> PBITS;
        a_d   = a_q >> PBITS;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNTW'(1)) state_d = S_FINAL;
      end
      S_FINAL: begin
        if (u_q >= UW'(m_q)) y_d = NBITS'(u_q - UW'(m_q));
        else                 y_d = u_q[NBITS-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        y_d     = '0;
        err_d   = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand, table and result registers; reset clears everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      mp_q    <= '0;
      cnt_q   <= '0;
      j_q     <= '0;
      tb_q    <= '{default: '0};
      tm_q    <= '{default: '0};
      u_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      mp_q    <= mp_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      tb_q    <= tb_d;
      tm_q    <= tm_d;
      u_q     <= u_d;
      y_q     <= y_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign y      = y_q;
  assign err    = err_q;
  assign done_p = done_q;

endmodule

// File: tb/tb_mont_mul_radix.sv
// Directed bench for mont_mul_radix: one radix-4 and one radix-2 instance
// (NBITS=8), driven from a vector table plus hand-written handshake and
// reset sequences.
module tb_mont_mul_radix;

  // Clock and shared operand buses; each DUT has its own start pulse
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] m = '0;
  logic [1:0] mp = '0;
  logic [3:0] ms = '0;

  logic       busy0, err0, done0;
  logic [7:0] y0;
  logic       busy1, err1, done1;
  logic [7:0] y1;

  bit         sel = 1'b0;
  logic       busyS, errS, doneS;
  logic [7:0] yS;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    logic [1:0] mp;
    logic [3:0] ms;
    logic [7:0] y;
    bit         err;
    int         lat;
  } vec_t;

  vec_t vecs [10];

  mont_mul_radix #(.NBITS(8), .PBITS(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start_p(start0),
    .a(a), .b(b), .m(m), .m_prime(mp), .m_size(ms),
    .busy(busy0), .y(y0), .err(err0), .done_p(done0)
  );

  mont_mul_radix #(.NBITS(8), .PBITS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start_p(start1),
    .a(a), .b(b), .m(m), .m_prime(mp[0:0]), .m_size(ms),
    .busy(busy1), .y(y1), .err(err1), .done_p(done1)
  );

  always #5 clk = ~clk;

  // Route the currently selected instance's outputs to common names
  always_comb begin
    busyS = sel ? busy1 : busy0;
    errS  = sel ? err1  : err0;
    doneS = sel ? done1 : done0;
    yS    = sel ? y1    : y0;
  end

  // One comparison: bumps the counters and reports a mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Launch one operation right after a rising edge and wait for done_p.
  // lat counts edges from the launch edge to the edge that raises done_p.
  // With intrude set, a second start with other operands hits mid-loop.
  task automatic applyStimulus(input vec_t v, input bit intrude,
                               output logic [7:0] yo, output logic erro,
                               output int lat, output int busyCnt,
                               output bit seen);
    sel = v.sel;
    a   = v.a;
    b   = v.b;
    m   = v.m;
    mp  = v.mp;
    ms  = v.ms;
    if (v.sel) start1 = 1'b1;
    else       start0 = 1'b1;
    @(posedge clk); #1;
    start0  = 1'b0;
    start1  = 1'b0;
    a       = ~v.a;
    b       = ~v.b;
    lat     = 1;
    busyCnt = busyS ? 1 : 0;
    while (!doneS && lat < 40) begin
      if (intrude && lat == 4) begin
        a  = 8'd12;
        b  = 8'd12;
        m  = 8'd29;
        ms = 4'd5;
        if (v.sel) start1 = 1'b1;
        else       start0 = 1'b1;
      end
      @(posedge clk); #1;
      start0 = 1'b0;
      start1 = 1'b0;
      lat++;
      if (busyS) busyCnt++;
    end
    seen = doneS;
    yo   = yS;
    erro = errS;
  endtask

  initial begin
    logic [7:0] ry, ry2;
    logic       rerr, rerr2;
    int         rlat, rlat2, rbusy, rbusy2, doneCount;
    bit         rseen, rseen2;

    // Vector table: {sel, a, b, m, m_prime, m_size, y, err, latency}
    vecs[0] = '{1'b0, 8'd5,  8'd7,  8'd13, 2'd3, 4'd4, 8'd3, 1'b0, 7};
    vecs[1] = '{1'b0, 8'd1,  8'd1,  8'd29, 2'd3, 4'd5, 8'd5, 1'b0, 8};
    vecs[2] = '{1'b0, 8'd12, 8'd12, 8'd13, 2'd3, 4'd4, 8'd9, 1'b0, 7};
    vecs[3] = '{1'b0, 8'd7,  8'd12, 8'd13, 2'd3, 4'd4, 8'd2, 1'b0, 7};
    vecs[4] = '{1'b0, 8'd28, 8'd28, 8'd29, 2'd3, 4'd5, 8'd5, 1'b0, 8};
    vecs[5] = '{1'b0, 8'd5,  8'd7,  8'd12, 2'd3, 4'd4, 8'd0, 1'b1, 2};
    vecs[6] = '{1'b0, 8'd5,  8'd7,  8'd13, 2'd3, 4'd4, 8'd3, 1'b0, 7};
    vecs[7] = '{1'b1, 8'd5,  8'd7,  8'd13, 2'd1, 4'd4, 8'd3, 1'b0, 7};
    vecs[8] = '{1'b1, 8'd0,  8'd7,  8'd13, 2'd1, 4'd4, 8'd0, 1'b0, 7};
    vecs[9] = '{1'b0, 8'd0,  8'd9,  8'd13, 2'd3, 4'd4, 8'd0, 1'b0, 7};

    // Hold reset for a few edges and check both instances come up cleared
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.busy4", busy0, 0);
    checkOutput("rst.y4",    y0,    0);
    checkOutput("rst.err4",  err0,  0);
    checkOutput("rst.done4", done0, 0);
    checkOutput("rst.busy2", busy1, 0);
    checkOutput("rst.y2",    y1,    0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven operations, each followed by a one-cycle done check
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], 1'b0, ry, rerr, rlat, rbusy, rseen);
      checkOutput($sformatf("vec%0d.done", i), rseen, 1);
      checkOutput($sformatf("vec%0d.y", i), ry, vecs[i].y);
      checkOutput($sformatf("vec%0d.err", i), rerr, vecs[i].err);
      checkOutput($sformatf("vec%0d.lat", i), rlat, vecs[i].lat);
      checkOutput($sformatf("vec%0d.busy", i), rbusy, vecs[i].lat - 1);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d.pulse", i), doneS, 0);
    end

    // Result must hold while idle
    applyStimulus(vecs[0], 1'b0, ry, rerr, rlat, rbusy, rseen);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("hold.y", y0, 3);
    checkOutput("hold.busy", busy0, 0);

    // A start pulse during the loop must not disturb the running operation
    applyStimulus(vecs[0], 1'b1, ry, rerr, rlat, rbusy, rseen);
    checkOutput("intr.y", ry, 3);
    checkOutput("intr.lat", rlat, 7);
    @(posedge clk); #1;
    checkOutput("intr.idle", busy0, 0);

    // Back-to-back: second start issued in the done_p cycle of the first
    applyStimulus(vecs[3], 1'b0, ry, rerr, rlat, rbusy, rseen);
    applyStimulus(vecs[1], 1'b0, ry2, rerr2, rlat2, rbusy2, rseen2);
    checkOutput("b2b.y1", ry, 2);
    checkOutput("b2b.y2", ry2, 5);
    checkOutput("b2b.lat2", rlat2, 8);
    checkOutput("b2b.seen2", rseen2, 1);

    // Reset pulse in the middle of the loop aborts without a done pulse
    @(posedge clk); #1;
    sel = 1'b0;
    a = 8'd5; b = 8'd7; m = 8'd13; mp = 2'd3; ms = 4'd4;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.busy", busy0, 0);
    checkOutput("midrst.y", y0, 0);
    checkOutput("midrst.done", done0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    doneCount = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done0) doneCount++;
    end
    checkOutput("midrst.nodone", doneCount, 0);
    applyStimulus(vecs[0], 1'b0, ry, rerr, rlat, rbusy, rseen);
    checkOutput("postrst.y", ry, 3);
    checkOutput("postrst.lat", rlat, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mont_mul_radix.md
Name: mont_mul_radix

Overview:
- Self-contained radix-2^PBITS Montgomery modular multiplier with a start/busy/done handshake.
- Computes y = a·b·2^(-PBITS·ITER) mod m, where ITER = ceil(m_size/PBITS).
- Builds its own digit-multiple tables for b and m in a precompute phase, so the upstream controller supplies only raw operands plus m_prime.
- Sits in the modexp datapath as the next-generation replacement for the fixed-table Montgomery core.

Parameters:
NBITS, 2048, maximum modulus/operand width in bits
PBITS, 2, radix exponent (bits of a consumed per iteration), 1..4
MLSIZE, 1<<PBITS, digit-multiple table depth (derived; do not override)
CNTW, $clog2(NBITS)+1, width of m_size and iteration counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_p  in  1  single-cycle start pulse; ignored while busy=1
a  in  NBITS  multiplier operand, a < m
b  in  NBITS  multiplicand operand, b < m
m  in  NBITS  modulus, must be odd, m < 2^m_size
m_prime  in  PBITS  (-m^-1) mod 2^PBITS, supplied by software
m_size  in  CNTW  modulus bit length, 1..NBITS
busy  out  1  high from the cycle after start is accepted until done_p
y  out  NBITS  result; held stable from done_p until the next accepted start
err  out  1  set with done_p when the sampled m was even; cleared on the next accepted start
done_p  out  1  one-cycle completion pulse

Behaviour:
- Reset: asynchronous, active-low, one clock (clk). All outputs and state are 0 on reset; FSM=IDLE; tables are cleared.
- Start capture: on start_p in IDLE, register a, b, m, m_prime and m_size, and clear err. Operands may change afterwards.
- IDLE -> PRE when m[0]=1. IDLE -> ERR when m[0]=0.
- ERR (1 cycle): sets err=1, y=0, then returns to IDLE with done_p.
- PRE (MLSIZE-1 cycles):
  - tb[0]=0, tm[0]=0.
  - Cycle j=1..MLSIZE-1 computes tb[j]=tb[j-1]+b and tm[j]=tm[j-1]+m.
  - Tables are NBITS+PBITS wide.
- LOOP (ITER cycles). Each cycle i:
  - d = a_sh[PBITS-1:0].
  - s = u + tb[d].
  - q = (s[PBITS-1:0]·m_prime) mod 2^PBITS.
  - u <= (s + tm[q]) >> PBITS.
  - a_sh <= a_sh >> PBITS.
  - ITER counter decrements to 0. When m_size is not a multiple of PBITS, the last iteration still consumes a full digit; the upper digit bits of a are 0.
  - u starts at 0 and is NBITS+PBITS+1 wide. Invariant: u < 2m after each iteration; no overflow is permitted.
- FINAL (1 cycle): y <= (u >= m) ? u-m : u, truncated to NBITS. Then go to IDLE.
- done_p: one-cycle pulse, registered, asserted in the cycle the FSM re-enters IDLE.
- Latency from the start_p edge to done_p: MLSIZE-1 + ITER + 2 cycles. ERR path: 2 cycles.
- busy: high in PRE, LOOP, FINAL and ERR. Low in the done_p cycle, so a start_p in that cycle is accepted (back-to-back operation).
- start_p while busy=1: ignored entirely; no state change.
- Reset mid-operation: immediate return to IDLE, busy=0, y=0, no done_p.
- m_size out of range (0 or >NBITS) or a/b not less than m: result undefined, but the FSM must still terminate within the latency formula, with m_size=0 treated as ITER=1.

Test Plan:
- NBITS=8, PBITS=2: m=13, m_prime=3, m_size=4, a=5, b=7 -> y=3, err=0, done_p exactly 7 cycles after the start edge, busy high for 6 cycles.
- NBITS=8, PBITS=2, odd m_size: m=29, m_prime=3, m_size=5, a=1, b=1 -> y=5 (64^-1 mod 29), done_p 8 cycles after start. Also m=13, a=b=12 -> y=9 (exercises the final subtract).
- NBITS=8, PBITS=1: m=13, m_prime=1, m_size=4, a=5, b=7 -> y=3, done_p 7 cycles after start. Also a=0 -> y=0.
- Even modulus m=12 -> err=1, y=0, done_p 2 cycles after start. The next valid start clears err.
- Handshake:
  - start_p pulsed during LOOP with different operands -> ignored; the first result is unchanged.
  - start_p in the done_p cycle -> accepted; the second result is correct.
  - y is held between operations.
- Reset: rst_n asserted low for 1 cycle mid-LOOP -> busy=0, y=0, no done_p. A subsequent operation (m=13, a=5, b=7) gives y=3.
